// File: rtl/bridge_arb_n.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_arb_n
//  Description : N-channel CPU-to-external-bus bridge. A round-robin arbiter
//                picks one requesting CPU channel and runs a single read or
//                write transfer on the external bus. A one-cycle RELEASE
//                phase then pulses the per-channel done flag and
//                ext_next_cpu_e before the arbiter returns to IDLE.
//  Optional    : BRIDGE_WATCHDOG_EN - adds a 16-bit XFER watchdog. When it
//                expires, the transfer is aborted and err pulses in RELEASE.
//  Ports       : clk, rst (async, active-high)
//                read_q/write_q/addr_in/data_in   - per-CPU request side
//                read_dn/write_dn/rd_data         - per-CPU completion side
//                ext_*                            - external bus master side
//                cpu_index, ext_next_cpu_e, bus_busy, err - status
//  Revision    : 1.0 - initial release
// ============================================================================
module bridge_arb_n #(
    parameter int N_CPU   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CPU-1:0]          read_q,
    input  logic [N_CPU-1:0]          write_q,
    input  logic [N_CPU*ADDR_W-1:0]   addr_in,
    input  logic [N_CPU*DATA_W-1:0]   data_in,
    output logic [N_CPU-1:0]          read_dn,
    output logic [N_CPU-1:0]          write_dn,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ADDR_W-1:0]         ext_addr,
    output logic [DATA_W-1:0]         ext_wdata,
    input  logic [DATA_W-1:0]         ext_rdata,
    output logic                      ext_read_q,
    output logic                      ext_write_q,
    input  logic                      ext_read_dn,
    input  logic                      ext_write_dn,
    output logic [3:0]                cpu_index,
    output logic                      ext_next_cpu_e,
    output logic                      bus_busy,
    output logic                      err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Reset value of last_grant makes channel 0 the first winner.
    localparam logic [3:0]  c_LAST_RST = 4'(N_CPU - 1);
    localparam logic [4:0]  c_NCPU     = 5'(N_CPU);
    localparam logic [15:0] c_TIMEOUT  = 16'(TIMEOUT);

    state_t              r_state;
    logic [3:0]          r_last_grant;
    logic [3:0]          r_cpu_index;
    logic                r_dir_rd;
    logic                r_ext_read_q;
    logic                r_ext_write_q;
    logic [ADDR_W-1:0]   r_ext_addr;
    logic [DATA_W-1:0]   r_ext_wdata;
    logic [DATA_W-1:0]   r_rd_data;
    logic [N_CPU-1:0]    r_read_dn;
    logic [N_CPU-1:0]    r_write_dn;
    logic                r_next_cpu_e;
    logic                r_bus_busy;

    // ------------------------------------------------------------------
    // Unpack channel inputs into 16-entry tables so that the 4-bit grant
    // index selects an entry directly; unused entries read as zero.
    // ------------------------------------------------------------------
    logic [15:0]         w_rq16;
    logic [ADDR_W-1:0]   w_addr [16];
    logic [DATA_W-1:0]   w_data [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
            if (gi < N_CPU) begin : g_used
                assign w_rq16[gi] = read_q[gi];
                assign w_addr[gi] = addr_in[gi*ADDR_W +: ADDR_W];
                assign w_data[gi] = data_in[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign w_rq16[gi] = 1'b0;
                assign w_addr[gi] = '0;
                assign w_data[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin arbiter. The duplicated request vector is rotated so
    // that bit 0 is channel last_grant+1. The lowest set bit of the
    // rotated vector is the winner. Its offset is then mapped back to a
    // channel number with one conditional subtraction; the sum is at
    // most 2*N_CPU-1, so a single subtraction is sufficient.
    // ------------------------------------------------------------------
    logic [N_CPU-1:0]    w_req;
    logic [4:0]          w_shamt;
    logic [N_CPU-1:0]    w_rot;
    logic [4:0]          w_sum;
    logic [4:0]          w_mod;
    logic [3:0]          w_grant;
    logic [N_CPU-1:0]    w_sel;

    assign w_req   = read_q | write_q;
    assign w_shamt = {1'b0, r_last_grant} + 5'd1;
    assign w_rot   = N_CPU'({w_req, w_req} >> w_shamt);

    always_comb begin
        w_sum = {1'b0, r_last_grant};
        for (int i = N_CPU - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_sum = w_shamt + 5'(i);
            end
        end
        w_mod = (w_sum >= c_NCPU) ? (w_sum - c_NCPU) : w_sum;
    end

    assign w_grant = 4'(w_mod);

    // One-hot select of the channel currently owning the bus.
    assign w_sel = {{(N_CPU-1){1'b0}}, 1'b1} << r_cpu_index;

`ifdef BRIDGE_WATCHDOG_EN
    logic [15:0] r_wdog;
    logic [15:0] w_wdog_nxt;
    logic        r_err;

    assign w_wdog_nxt = r_wdog + 16'd1;
    assign err        = r_err;
`else
    logic w_unused;

    assign w_unused = ^c_TIMEOUT;
    assign err      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM. All outputs are registered here. Because rst is an
    // asynchronous reset, the strobes drop as soon as rst rises.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= c_LAST_RST;
            r_cpu_index   <= 4'd0;
            r_dir_rd      <= 1'b0;
            r_ext_read_q  <= 1'b0;
            r_ext_write_q <= 1'b0;
            r_ext_addr    <= '0;
            r_ext_wdata   <= '0;
            r_rd_data     <= '0;
            r_read_dn     <= '0;
            r_write_dn    <= '0;
            r_next_cpu_e  <= 1'b0;
            r_bus_busy    <= 1'b0;
`ifdef BRIDGE_WATCHDOG_EN
            r_wdog        <= 16'd0;
            r_err         <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_state       <= ST_XFER;
                        r_cpu_index   <= w_grant;
                        r_ext_addr    <= w_addr[w_grant];
                        r_ext_wdata   <= w_data[w_grant];
                        // When both request bits are set, the read is served first.
                        r_dir_rd      <= w_rq16[w_grant];
                        r_ext_read_q  <= w_rq16[w_grant];
                        r_ext_write_q <= ~w_rq16[w_grant];
                        r_bus_busy    <= 1'b1;
`ifdef BRIDGE_WATCHDOG_EN
                        r_wdog        <= 16'd0;
`endif
                    end
                end

                ST_XFER: begin
`ifdef BRIDGE_WATCHDOG_EN
                    r_wdog <= w_wdog_nxt;
`endif
                    // Only the done of the latched direction counts. A done
                    // that arrives on the timeout cycle takes priority.
                    if (r_dir_rd ? ext_read_dn : ext_write_dn) begin
                        r_state       <= ST_RELEASE;
                        r_ext_read_q  <= 1'b0;
                        r_ext_write_q <= 1'b0;
                        r_next_cpu_e  <= 1'b1;
                        r_last_grant  <= r_cpu_index;
                        if (r_dir_rd) begin
                            r_read_dn <= w_sel;
                            r_rd_data <= ext_rdata;
                        end else begin
                            r_write_dn <= w_sel;
                        end
                    end
`ifdef BRIDGE_WATCHDOG_EN
                    else if (w_wdog_nxt == c_TIMEOUT) begin
                        r_state       <= ST_RELEASE;
                        r_ext_read_q  <= 1'b0;
                        r_ext_write_q <= 1'b0;
                        r_next_cpu_e  <= 1'b1;
                        r_last_grant  <= r_cpu_index;
                        r_err         <= 1'b1;
                        if (r_dir_rd) begin
                            r_read_dn <= w_sel;
                            r_rd_data <= '0;
                        end else begin
                            r_write_dn <= w_sel;
                        end
                    end
`endif
                end

                ST_RELEASE: begin
                    r_state      <= ST_IDLE;
                    r_read_dn    <= '0;
                    r_write_dn   <= '0;
                    r_next_cpu_e <= 1'b0;
                    r_bus_busy   <= 1'b0;
`ifdef BRIDGE_WATCHDOG_EN
                    r_err        <= 1'b0;
`endif
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_dn        = r_read_dn;
    assign write_dn       = r_write_dn;
    assign rd_data        = r_rd_data;
    assign ext_addr       = r_ext_addr;
    assign ext_wdata      = r_ext_wdata;
    assign ext_read_q     = r_ext_read_q;
    assign ext_write_q    = r_ext_write_q;
    assign cpu_index      = r_cpu_index;
    assign ext_next_cpu_e = r_next_cpu_e;
    assign bus_busy       = r_bus_busy;

endmodule
`default_nettype wire

// File: tb/tb_bridge_arb_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bridge_arb_n
//  Description : Self-checking bench for bridge_arb_n (N_CPU=4, TIMEOUT=8).
//                The reference model keeps last_grant and the last read data,
//                and picks grants by scanning channels last+1.. modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bridge_arb_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      read_q, write_q;
    logic [N*AW-1:0]   addr_in;
    logic [N*DW-1:0]   data_in;
    logic [N-1:0]      read_dn, write_dn;
    logic [DW-1:0]     rd_data;
    logic [AW-1:0]     ext_addr;
    logic [DW-1:0]     ext_wdata;
    logic [DW-1:0]     ext_rdata;
    logic              ext_read_q, ext_write_q;
    logic              ext_read_dn, ext_write_dn;
    logic [3:0]        cpu_index;
    logic              ext_next_cpu_e, bus_busy, err;

    always #5 clk = ~clk;

    bridge_arb_n #(.N_CPU(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .read_q(read_q), .write_q(write_q),
        .addr_in(addr_in), .data_in(data_in),
        .read_dn(read_dn), .write_dn(write_dn), .rd_data(rd_data),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
        .ext_read_q(ext_read_q), .ext_write_q(ext_write_q),
        .ext_read_dn(ext_read_dn), .ext_write_dn(ext_write_dn),
        .cpu_index(cpu_index), .ext_next_cpu_e(ext_next_cpu_e),
        .bus_busy(bus_busy), .err(err)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          m_last;        // model: last granted channel
    logic [31:0] m_rd;          // model: rd_data

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference round-robin pick: first requester after 'last', wrapping.
    function automatic int rr_pick(input int last, input int req);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (((req >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; read_q = '0; write_q = '0; addr_in = '0; data_in = '0;
        ext_rdata = '0; ext_read_dn = 1'b0; ext_write_dn = 1'b0;
        repeat (3) tick();
        n_cmp++; if ({read_dn, write_dn, ext_read_q, ext_write_q, ext_next_cpu_e, bus_busy, err, cpu_index} !== '0) begin n_fail++; $display("FAIL reset_ctrl: got rd=%b wd=%b rq=%b wq=%b nx=%b bb=%b er=%b ci=%0d want all 0", read_dn, write_dn, ext_read_q, ext_write_q, ext_next_cpu_e, bus_busy, err, cpu_index); end
        n_cmp++; if ({rd_data, ext_addr, ext_wdata} !== '0) begin n_fail++; $display("FAIL reset_data: got rd=%h a=%h w=%h want 0", rd_data, ext_addr, ext_wdata); end
        read_q = 4'b1111;
        tick();
        n_cmp++; if (bus_busy !== 1'b0 || ext_read_q !== 1'b0) begin n_fail++; $display("FAIL reset_hold_idle: got bb=%b rq=%b want 0 0", bus_busy, ext_read_q); end
        read_q = '0;
        #2 rst = 1'b0;
        tick();
        m_last = N - 1; m_rd = '0;
    endtask

    task automatic test_single_read();
        addr_in[0 +: AW] = 32'h100; data_in[0 +: DW] = 32'h1111_2222;
        read_q = 4'b0001;
        tick();
        n_cmp++; if (ext_read_q !== 1'b1 || ext_write_q !== 1'b0) begin n_fail++; $display("FAIL single_strobe: got r=%b w=%b want 1 0", ext_read_q, ext_write_q); end
        n_cmp++; if (cpu_index !== 4'd0 || ext_addr !== 32'h100 || bus_busy !== 1'b1) begin n_fail++; $display("FAIL single_latch: got ci=%0d a=%h bb=%b want 0 100 1", cpu_index, ext_addr, bus_busy); end
        read_q = '0;
        tick(); tick();
        n_cmp++; if (ext_read_q !== 1'b1 || read_dn !== '0) begin n_fail++; $display("FAIL single_wait: got r=%b dn=%b want 1 0", ext_read_q, read_dn); end
        ext_rdata = 32'hDEAD_BEEF; ext_read_dn = 1'b1;
        tick();
        n_cmp++; if (read_dn !== 4'b0001 || write_dn !== '0 || ext_next_cpu_e !== 1'b1) begin n_fail++; $display("FAIL single_release: got rd=%b wd=%b nx=%b want 0001 0000 1", read_dn, write_dn, ext_next_cpu_e); end
        n_cmp++; if (rd_data !== 32'hDEAD_BEEF || ext_read_q !== 1'b0 || bus_busy !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL single_data: got d=%h r=%b bb=%b er=%b want deadbeef 0 1 0", rd_data, ext_read_q, bus_busy, err); end
        ext_read_dn = 1'b0; ext_rdata = '0;
        tick();
        n_cmp++; if (bus_busy !== 1'b0 || read_dn !== '0 || cpu_index !== 4'd0 || rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_idle: got bb=%b dn=%b ci=%0d d=%h want 0 0 0 deadbeef", bus_busy, read_dn, cpu_index, rd_data); end
        m_last = 0; m_rd = 32'hDEAD_BEEF;
    endtask

    task automatic test_read_wins();
        logic [31:0] r, wd;
        r = $urandom; wd = $urandom;
        addr_in[2*AW +: AW] = 32'h0000_2200; data_in[2*DW +: DW] = wd;
        read_q = 4'b0100; write_q = 4'b0100;
        tick();
        n_cmp++; if (ext_read_q !== 1'b1 || ext_write_q !== 1'b0 || cpu_index !== 4'd2) begin n_fail++; $display("FAIL rw_read_first: got r=%b w=%b ci=%0d want 1 0 2", ext_read_q, ext_write_q, cpu_index); end
        read_q = '0; ext_write_dn = 1'b1;  // opposite done must be ignored
        tick();
        n_cmp++; if (ext_read_q !== 1'b1 || read_dn !== '0 || write_dn !== '0) begin n_fail++; $display("FAIL rw_ignore_wdone: got r=%b rd=%b wd=%b want 1 0 0", ext_read_q, read_dn, write_dn); end
        ext_write_dn = 1'b0; ext_read_dn = 1'b1; ext_rdata = r;
        tick();
        n_cmp++; if (read_dn !== 4'b0100 || write_dn !== '0 || rd_data !== r) begin n_fail++; $display("FAIL rw_read_done: got rd=%b wd=%b d=%h want 0100 0000 %h", read_dn, write_dn, rd_data, r); end
        ext_read_dn = 1'b0;
        tick();
        tick();
        n_cmp++; if (ext_write_q !== 1'b1 || ext_read_q !== 1'b0 || cpu_index !== 4'd2 || ext_wdata !== wd) begin n_fail++; $display("FAIL rw_write_next: got w=%b r=%b ci=%0d wd=%h want 1 0 2 %h", ext_write_q, ext_read_q, cpu_index, ext_wdata, wd); end
        write_q = '0; ext_write_dn = 1'b1;
        tick();
        n_cmp++; if (write_dn !== 4'b0100 || read_dn !== '0 || rd_data !== r) begin n_fail++; $display("FAIL rw_write_done: got wd=%b rd=%b d=%h want 0100 0000 %h", write_dn, read_dn, rd_data, r); end
        ext_write_dn = 1'b0;
        tick();
        m_last = 2; m_rd = r;
    endtask

    task automatic test_round_robin();
        logic [31:0] r;
        int g;
        rst = 1'b1; tick(); rst = 1'b0;
        m_last = N - 1; m_rd = '0;
        read_q = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            g = rr_pick(m_last, 15);
            tick();
            n_cmp++; if (ext_read_q !== 1'b1 || cpu_index !== 4'(g)) begin n_fail++; $display("FAIL rr_grant%0d: got r=%b ci=%0d want 1 %0d", t, ext_read_q, cpu_index, g); end
            r = $urandom; ext_rdata = r; ext_read_dn = 1'b1;
            if (t == 4) read_q = '0;
            tick();
            n_cmp++; if (read_dn !== 4'(1 << g) || rd_data !== r) begin n_fail++; $display("FAIL rr_release%0d: got dn=%b d=%h want %b %h", t, read_dn, rd_data, 4'(1 << g), r); end
            ext_read_dn = 1'b0;
            tick();
            n_cmp++; if (bus_busy !== 1'b0 || ext_read_q !== 1'b0) begin n_fail++; $display("FAIL rr_gap%0d: got bb=%b r=%b want 0 0", t, bus_busy, ext_read_q); end
            m_last = g; m_rd = r;
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        read_q = 4'b0010;
        tick();
        n_cmp++; if (ext_read_q !== 1'b1 || cpu_index !== 4'd1) begin n_fail++; $display("FAIL ar_grant1: got r=%b ci=%0d want 1 1", ext_read_q, cpu_index); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (ext_read_q !== 1'b0 || bus_busy !== 1'b0 || read_dn !== '0 || err !== 1'b0 || cpu_index !== 4'd0) begin n_fail++; $display("FAIL ar_async_drop: got r=%b bb=%b dn=%b er=%b ci=%0d want 0 0 0 0 0", ext_read_q, bus_busy, read_dn, err, cpu_index); end
        #2 rst = 1'b0; read_q = 4'b0011;
        m_last = N - 1; m_rd = '0;
        tick();
        n_cmp++; if (cpu_index !== 4'(rr_pick(m_last, 3)) || ext_read_q !== 1'b1) begin n_fail++; $display("FAIL ar_ch0_first: got ci=%0d r=%b want 0 1", cpu_index, ext_read_q); end
        read_q = 4'b0010; r = $urandom; ext_rdata = r; ext_read_dn = 1'b1;
        tick();
        n_cmp++; if (read_dn !== 4'b0001) begin n_fail++; $display("FAIL ar_ch0_done: got %b want 0001", read_dn); end
        ext_read_dn = 1'b0; m_last = 0;
        tick();
        tick();
        n_cmp++; if (cpu_index !== 4'(rr_pick(m_last, 2)) || ext_read_q !== 1'b1) begin n_fail++; $display("FAIL ar_ch1_next: got ci=%0d r=%b want 1 1", cpu_index, ext_read_q); end
        read_q = '0; r = $urandom; ext_rdata = r; ext_read_dn = 1'b1;
        tick();
        ext_read_dn = 1'b0;
        tick();
        m_last = 1; m_rd = r;
    endtask

    task automatic test_random();
        logic [31:0] ea [N];
        logic [31:0] ed [N];
        logic [31:0] r;
        int rq, wq, g, lat;
        bit rd;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                ea[i] = $urandom; ed[i] = $urandom;
                addr_in[i*AW +: AW] = ea[i]; data_in[i*DW +: DW] = ed[i];
            end
            rq = int'($urandom_range(0, 15)); wq = int'($urandom_range(0, 15));
            if ((rq | wq) == 0) wq = 1 << $urandom_range(0, N - 1);
            read_q = 4'(rq); write_q = 4'(wq);
            g  = rr_pick(m_last, rq | wq);
            rd = ((rq >> g) & 1) != 0;
            tick();
            n_cmp++; if (cpu_index !== 4'(g) || ext_read_q !== rd || ext_write_q !== !rd || bus_busy !== 1'b1) begin n_fail++; $display("FAIL rnd_grant%0d: got ci=%0d r=%b w=%b bb=%b want %0d %b %b 1", it, cpu_index, ext_read_q, ext_write_q, bus_busy, g, rd, !rd); end
            n_cmp++; if (ext_addr !== ea[g] || ext_wdata !== ed[g]) begin n_fail++; $display("FAIL rnd_latch%0d: got a=%h w=%h want %h %h", it, ext_addr, ext_wdata, ea[g], ed[g]); end
            read_q = '0; write_q = '0;
            lat = int'($urandom_range(0, 3));
            for (int j = 0; j < lat; j++) begin
                ext_rdata = $urandom;
                if (rd) ext_write_dn = 1'($urandom_range(0, 1));
                else    ext_read_dn  = 1'($urandom_range(0, 1));
                tick();
                n_cmp++; if ((rd ? ext_read_q : ext_write_q) !== 1'b1 || read_dn !== '0 || write_dn !== '0) begin n_fail++; $display("FAIL rnd_wait%0d: got strobe=%b rd=%b wd=%b want 1 0 0", it, rd ? ext_read_q : ext_write_q, read_dn, write_dn); end
            end
            r = $urandom; ext_rdata = r;
            ext_read_dn = rd; ext_write_dn = !rd;
            if (rd) m_rd = r;
            tick();
            n_cmp++; if (read_dn !== (rd ? 4'(1 << g) : 4'b0) || write_dn !== (rd ? 4'b0 : 4'(1 << g))) begin n_fail++; $display("FAIL rnd_dn%0d: got rd=%b wd=%b want ch %0d read=%b", it, read_dn, write_dn, g, rd); end
            n_cmp++; if (rd_data !== m_rd || ext_next_cpu_e !== 1'b1 || ext_read_q !== 1'b0 || ext_write_q !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rnd_rel%0d: got d=%h nx=%b r=%b w=%b er=%b want %h 1 0 0 0", it, rd_data, ext_next_cpu_e, ext_read_q, ext_write_q, err, m_rd); end
            ext_read_dn = 1'b0; ext_write_dn = 1'b0;
            tick();
            n_cmp++; if (bus_busy !== 1'b0 || ext_next_cpu_e !== 1'b0 || cpu_index !== 4'(g)) begin n_fail++; $display("FAIL rnd_idle%0d: got bb=%b nx=%b ci=%0d want 0 0 %0d", it, bus_busy, ext_next_cpu_e, cpu_index, g); end
            m_last = g;
        end
    endtask

    task automatic test_watchdog();
        int g;
        g = rr_pick(m_last, 8);
        read_q = 4'b1000;
        tick();
        n_cmp++; if (ext_read_q !== 1'b1 || cpu_index !== 4'(g)) begin n_fail++; $display("FAIL wd_grant: got r=%b ci=%0d want 1 %0d", ext_read_q, cpu_index, g); end
        read_q = '0;
`ifdef BRIDGE_WATCHDOG_EN
        for (int k = 2; k <= TO; k++) begin
            tick();
            n_cmp++; if (ext_read_q !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL wd_xfer_cyc%0d: got r=%b er=%b want 1 0", k, ext_read_q, err); end
        end
        tick();
        n_cmp++; if (err !== 1'b1 || read_dn !== 4'(1 << g) || rd_data !== '0 || ext_read_q !== 1'b0 || ext_next_cpu_e !== 1'b1) begin n_fail++; $display("FAIL wd_abort: got er=%b dn=%b d=%h r=%b nx=%b want 1 %b 0 0 1", err, read_dn, rd_data, ext_read_q, ext_next_cpu_e, 4'(1 << g)); end
        m_rd = '0;
        tick();
        n_cmp++; if (err !== 1'b0 || bus_busy !== 1'b0) begin n_fail++; $display("FAIL wd_idle: got er=%b bb=%b want 0 0", err, bus_busy); end
`else
        for (int k = 2; k <= 3 * TO; k++) begin
            tick();
            n_cmp++; if (ext_read_q !== 1'b1 || err !== 1'b0 || read_dn !== '0) begin n_fail++; $display("FAIL wd_nowdog_cyc%0d: got r=%b er=%b dn=%b want 1 0 0", k, ext_read_q, err, read_dn); end
        end
        ext_rdata = 32'h0BAD_F00D; ext_read_dn = 1'b1;
        tick();
        n_cmp++; if (read_dn !== 4'(1 << g) || err !== 1'b0 || rd_data !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wd_nowdog_done: got dn=%b er=%b d=%h want %b 0 0badf00d", read_dn, err, rd_data, 4'(1 << g)); end
        ext_read_dn = 1'b0; m_rd = 32'h0BAD_F00D;
        tick();
`endif
        m_last = g;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_read_wins();
        test_round_robin();
        test_async_reset();
        test_random();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bridge_arb_n.md
BRIDGE_ARB_N -- requirements
Module: bridge_arb_n

Interface
REQ-001 Parameter N_CPU, default 4, number of CPU request channels (2..16).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 Parameter TIMEOUT, default 255, watchdog limit in cycles (1..65535).
REQ-005 Clocking and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
REQ-006 The ports SHALL be as follows:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- read_q  in  N_CPU  per-CPU read request.
- write_q  in  N_CPU  per-CPU write request.
- addr_in  in  N_CPU*ADDR_W  per-CPU address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- data_in  in  N_CPU*DATA_W  per-CPU write data; same packing as addr_in.
- read_dn  out  N_CPU  per-CPU read-complete pulse.
- write_dn  out  N_CPU  per-CPU write-complete pulse.
- rd_data  out  DATA_W  returned read data.
- ext_addr  out  ADDR_W  external bus address.
- ext_wdata  out  DATA_W  external write data.
- ext_rdata  in  DATA_W  external read data.
- ext_read_q  out  1  external read strobe.
- ext_write_q  out  1  external write strobe.
- ext_read_dn  in  1  external read done.
- ext_write_dn  in  1  external write done.
- cpu_index  out  4  index of the granted CPU.
- ext_next_cpu_e  out  1  grant-release pulse.
- bus_busy  out  1  transfer in progress.
- err  out  1  watchdog abort pulse.

Function
REQ-007 The FSM SHALL have three states: IDLE, XFER and RELEASE.
REQ-008 In IDLE, if any read_q|write_q bit is sampled high, the block SHALL select channel g by round-robin, searching from last_grant+1 modulo N_CPU, and SHALL enter XFER on the next edge.
REQ-009 On entry to XFER the block SHALL latch cpu_index=g, ext_addr, ext_wdata and direction; if read_q[g] and write_q[g] are both high, read wins.
REQ-010 In XFER exactly one of ext_read_q/ext_write_q SHALL be high, matching the latched direction; they are never high together; latency from request edge to strobe is 1 cycle.
REQ-011 In XFER, a done signal of the latched direction sampled high SHALL move the FSM to RELEASE; the opposite done signal SHALL be ignored.
REQ-012 On a read, rd_data SHALL capture ext_rdata on the same edge that enters RELEASE; rd_data holds until the next read completes.
REQ-013 In RELEASE, for one cycle: read_dn[g] or write_dn[g]=1, ext_next_cpu_e=1, strobes=0, last_grant=g; the FSM then returns to IDLE.
REQ-014 bus_busy SHALL be 1 in XFER and RELEASE and 0 in IDLE.
REQ-015 A request withdrawn during XFER SHALL NOT abort the transfer; it completes normally.
REQ-016 A request still high in the IDLE cycle after RELEASE SHALL be treated as a new request and arbitrated against the others; back-to-back grants therefore have a 1-cycle IDLE gap.
REQ-017 cpu_index SHALL hold its value outside XFER/RELEASE; N_CPU>16 is unsupported.

Reset
REQ-018 While rst=1 the FSM SHALL be in IDLE, all outputs 0, and last_grant=N_CPU-1, so channel 0 has priority after reset.
REQ-019 rst asserted mid-XFER SHALL drop the strobes immediately without waiting for a clock edge; no dn pulse and no err are issued.

Configuration
REQ-020 Macro BRIDGE_WATCHDOG_EN defined:
- a 16-bit counter clears on XFER entry and increments each XFER cycle.
- when the counter reaches TIMEOUT without done, the FSM enters RELEASE with err=1 for that cycle.
- the dn pulse for g is still issued; rd_data is forced to 0 on a read abort.
- a done signal arriving on the timeout cycle takes priority: normal completion, err=0.
REQ-021 Macro undefined: no counter is present, err is tied 0, and XFER waits indefinitely.

Verification
REQ-022 Reset, then read_q=4'b0001, addr=0x100, ext_read_dn high 3 cycles after the strobe with ext_rdata=0xDEADBEEF -> ext_read_q high on cycle 1, read_dn[0] pulse, rd_data=0xDEADBEEF, cpu_index=0.
REQ-023 All four read_q held high, done returned after 1 cycle -> grant order 0,1,2,3,0, each grant separated by RELEASE+IDLE.
REQ-024 read_q[2] and write_q[2] both high -> only ext_read_q asserts; write_q[2] is serviced on the next round-robin turn.
REQ-025 rst pulsed during XFER of channel 1 -> strobes drop asynchronously; after release, channel 0 has priority over 1.
REQ-026 With BRIDGE_WATCHDOG_EN and TIMEOUT=8, no done -> err and read_dn[g] pulse after 8 XFER cycles, rd_data=0; without the macro the strobe stays high.
